// File: rtl/peak_tracker.sv
// peak_tracker: streaming running-maximum tracker driving an external 16-bit magnitude comparator
module peak_tracker #(
    parameter int STREAK_LEN = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    input  logic        clear,
    input  logic        cmp_gt,
    input  logic        cmp_lt,
    input  logic        cmp_eq,
    output logic [15:0] cmp_a,
    output logic [15:0] cmp_b,
    output logic [15:0] peak,
    output logic        peak_valid,
    output logic        new_peak,
    output logic [7:0]  peak_count,
    output logic        peak_stable,
    output logic        cmp_error
);
    typedef enum logic [1:0] {EMPTY, TRACK, STABLE} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(STREAK_LEN);

    state_t      state_q, state_d;
    logic [15:0] s_reg_q, s_reg_d;
    logic        s_pend_q, s_pend_d;
    logic [15:0] peak_q, peak_d;
    logic [7:0]  count_q, count_d;
    logic [3:0]  streak_q, streak_d;
    logic        new_peak_q, new_peak_d;
    logic        err_q, err_d;
    logic        one_hot;
    logic [3:0]  streak_inc;
    logic [7:0]  count_inc;

    assign one_hot    = (cmp_gt ^ cmp_lt ^ cmp_eq) & ~(cmp_gt & cmp_lt & cmp_eq);
    assign streak_inc = (streak_q < STREAK_MAX) ? streak_q + 4'd1 : streak_q;
    assign count_inc  = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

    assign cmp_a       = s_reg_q;
    assign cmp_b       = peak_q;
    assign peak        = peak_q;
    assign peak_valid  = state_q != EMPTY;
    assign peak_stable = state_q == STABLE;
    assign new_peak    = new_peak_q;
    assign peak_count  = count_q;
    assign cmp_error   = err_q;

    // Next state: clear dominates, then the pending sample is judged against the stored peak
    always_comb begin
        state_d    = state_q;
        s_reg_d    = sample_valid ? sample_data : s_reg_q;
        s_pend_d   = sample_valid;
        peak_d     = peak_q;
        count_d    = count_q;
        streak_d   = streak_q;
        new_peak_d = 1'b0;
        err_d      = err_q;
        if (clear) begin
            state_d  = EMPTY;
            s_reg_d  = '0;
            s_pend_d = 1'b0;
            peak_d   = '0;
            count_d  = '0;
            streak_d = '0;
        end else if (s_pend_q) begin
            if (state_q == EMPTY) begin
                peak_d     = s_reg_q;
                new_peak_d = 1'b1;
                count_d    = 8'd1;
                streak_d   = '0;
                state_d    = TRACK;
            end else if (!one_hot) begin
                err_d = 1'b1;
            end else if (cmp_gt) begin
                peak_d     = s_reg_q;
                new_peak_d = 1'b1;
                count_d    = count_inc;
                streak_d   = '0;
                state_d    = TRACK;
            end else if (cmp_eq) begin
                streak_d = streak_inc;
                state_d  = (streak_inc >= STREAK_MAX) ? STABLE : state_q;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= EMPTY;
            s_reg_q    <= '0;
            s_pend_q   <= 1'b0;
            peak_q     <= '0;
            count_q    <= '0;
            streak_q   <= '0;
            new_peak_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_reg_q    <= s_reg_d;
            s_pend_q   <= s_pend_d;
            peak_q     <= peak_d;
            count_q    <= count_d;
            streak_q   <= streak_d;
            new_peak_q <= new_peak_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_peak_tracker.sv
// tb_peak_tracker: directed vector table plus randomized stream checked against a running-max model
module tb_peak_tracker;
    localparam int L = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic        clear = 1'b0;
    logic        bad = 1'b0;
    logic        cmp_gt, cmp_lt, cmp_eq;
    logic [15:0] cmp_a, cmp_b, peak;
    logic        peak_valid, new_peak, peak_stable, cmp_error;
    logic [7:0]  peak_count;

    int n_chk = 0;
    int n_fail = 0;

    // model state
    logic [15:0] m_sreg;
    logic        m_pend, m_valid, m_np, m_err;
    logic [15:0] m_peak;
    int          m_cnt, m_streak;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        c;
        logic        bad;
        logic [15:0] a;
        logic [15:0] pk;
        logic [7:0]  cnt;
        logic        np;
        logic        st;
        logic        err;
    } vec_t;
    vec_t tbl[$];

    peak_tracker #(.STREAK_LEN(L)) dut (
        .clk(clk), .n_rst(n_rst), .sample_valid(sample_valid), .sample_data(sample_data),
        .clear(clear), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .peak(peak), .peak_valid(peak_valid),
        .new_peak(new_peak), .peak_count(peak_count), .peak_stable(peak_stable),
        .cmp_error(cmp_error)
    );

    // external comparator, with a fault override producing gt=lt=1
    assign cmp_gt = bad | (cmp_a > cmp_b);
    assign cmp_lt = bad | (cmp_a < cmp_b);
    assign cmp_eq = ~bad & (cmp_a == cmp_b);

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sreg = '0; m_pend = 0; m_valid = 0; m_np = 0; m_err = 0;
        m_peak = '0; m_cnt = 0; m_streak = 0;
    endtask

    // running maximum rules applied to the sample captured one edge earlier
    task automatic model_edge(input logic v, input logic [15:0] d, input logic c, input logic b);
        m_np = 0;
        if (c) begin
            m_valid = 0; m_peak = '0; m_cnt = 0; m_streak = 0; m_pend = 0; m_sreg = '0;
        end else begin
            if (m_pend) begin
                if (!m_valid) begin
                    m_valid = 1; m_peak = m_sreg; m_cnt = 1; m_streak = 0; m_np = 1;
                end else if (b) begin
                    m_err = 1;
                end else if (m_sreg > m_peak) begin
                    m_peak = m_sreg; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255; m_streak = 0; m_np = 1;
                end else if (m_sreg == m_peak) begin
                    m_streak = (m_streak < L) ? m_streak + 1 : L;
                end
            end
            m_pend = v;
            if (v) m_sreg = d;
        end
    endtask

    task automatic cyc(input logic v, input logic [15:0] d, input logic c, input logic b);
        sample_valid = v; sample_data = d; clear = c; bad = b;
        @(posedge clk);
        model_edge(v, d, c, b);
        @(negedge clk);
    endtask

    task automatic chk_model();
        chk("cmp_a", cmp_a, m_sreg);
        chk("cmp_b", cmp_b, m_peak);
        chk("peak", peak, m_peak);
        chk("peak_valid", 16'(peak_valid), 16'(m_valid));
        chk("new_peak", 16'(new_peak), 16'(m_np));
        chk("peak_count", 16'(peak_count), 16'(m_cnt));
        chk("peak_stable", 16'(peak_stable), 16'(m_valid && m_streak >= L));
        chk("cmp_error", 16'(cmp_error), 16'(m_err));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " cmp_a"}, cmp_a, 16'h0);
        chk({tag, " cmp_b"}, cmp_b, 16'h0);
        chk({tag, " peak"}, peak, 16'h0);
        chk({tag, " peak_valid"}, 16'(peak_valid), 16'h0);
        chk({tag, " new_peak"}, 16'(new_peak), 16'h0);
        chk({tag, " peak_count"}, 16'(peak_count), 16'h0);
        chk({tag, " peak_stable"}, 16'(peak_stable), 16'h0);
        chk({tag, " cmp_error"}, 16'(cmp_error), 16'h0);
    endtask

    task automatic add(input logic v, input logic [15:0] d, input logic c, input logic b,
                       input logic [15:0] a, input logic [15:0] pk, input logic [7:0] cnt,
                       input logic np, input logic st, input logic err);
        vec_t r;
        r.v = v; r.d = d; r.c = c; r.bad = b; r.a = a; r.pk = pk;
        r.cnt = cnt; r.np = np; r.st = st; r.err = err;
        tbl.push_back(r);
    endtask

    initial begin
        // rising sequence 0x10, 0x20, 0x15
        add(1, 16'h0010, 0, 0, 16'h0010, 16'h0000, 0, 0, 0, 0);
        add(1, 16'h0020, 0, 0, 16'h0020, 16'h0010, 1, 1, 0, 0);
        add(1, 16'h0015, 0, 0, 16'h0015, 16'h0020, 2, 1, 0, 0);
        add(0, 16'h0000, 0, 0, 16'h0015, 16'h0020, 2, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        // equal streak to stable, then a larger sample
        add(1, 16'h1234, 0, 0, 16'h1234, 16'h0000, 0, 0, 0, 0);
        add(1, 16'h1234, 0, 0, 16'h1234, 16'h1234, 1, 1, 0, 0);
        add(1, 16'h1234, 0, 0, 16'h1234, 16'h1234, 1, 0, 0, 0);
        add(1, 16'h1234, 0, 0, 16'h1234, 16'h1234, 1, 0, 0, 0);
        add(1, 16'h1234, 0, 0, 16'h1234, 16'h1234, 1, 0, 0, 0);
        add(1, 16'h1234, 0, 0, 16'h1234, 16'h1234, 1, 0, 1, 0);
        add(1, 16'h1235, 0, 0, 16'h1235, 16'h1234, 1, 0, 1, 0);
        add(0, 16'h0000, 0, 0, 16'h1235, 16'h1235, 2, 1, 0, 0);
        add(0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        // 0xFFFF then 0x0000
        add(1, 16'hFFFF, 0, 0, 16'hFFFF, 16'h0000, 0, 0, 0, 0);
        add(1, 16'h0000, 0, 0, 16'h0000, 16'hFFFF, 1, 1, 0, 0);
        add(0, 16'h0000, 0, 0, 16'h0000, 16'hFFFF, 1, 0, 0, 0);
        // clear together with a new sample while a compare is pending
        add(1, 16'h0030, 0, 0, 16'h0030, 16'hFFFF, 1, 0, 0, 0);
        add(1, 16'h0050, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        add(1, 16'h0003, 0, 0, 16'h0003, 16'h0000, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 16'h0003, 16'h0003, 1, 1, 0, 0);
        // bad verdict on a would-be replacement, error survives clear
        add(0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        add(1, 16'h0010, 0, 0, 16'h0010, 16'h0000, 0, 0, 0, 0);
        add(1, 16'h0020, 0, 0, 16'h0020, 16'h0010, 1, 1, 0, 0);
        add(0, 16'h0000, 0, 1, 16'h0020, 16'h0010, 1, 0, 0, 1);
        add(0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 1);

        model_reset();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        n_rst = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].bad);
            chk($sformatf("v%0d cmp_a", i), cmp_a, tbl[i].a);
            chk($sformatf("v%0d cmp_b", i), cmp_b, tbl[i].pk);
            chk($sformatf("v%0d peak", i), peak, tbl[i].pk);
            chk($sformatf("v%0d peak_count", i), 16'(peak_count), 16'(tbl[i].cnt));
            chk($sformatf("v%0d peak_valid", i), 16'(peak_valid), 16'(tbl[i].cnt != 0));
            chk($sformatf("v%0d new_peak", i), 16'(new_peak), 16'(tbl[i].np));
            chk($sformatf("v%0d peak_stable", i), 16'(peak_stable), 16'(tbl[i].st));
            chk($sformatf("v%0d cmp_error", i), 16'(cmp_error), 16'(tbl[i].err));
        end

        // count saturation with 300 strictly increasing samples
        for (int i = 0; i < 300; i++) cyc(1, 16'(i + 1), 0, 0);
        cyc(0, 16'h0, 0, 0);
        chk("sat peak", peak, 16'd300);
        chk("sat peak_count", 16'(peak_count), 16'd255);
        chk_model();

        // randomized stream with an asynchronous reset in the middle
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 3) != 0, 16'($urandom_range(0, 40)),
                $urandom_range(0, 49) == 0, $urandom_range(0, 59) == 0);
            chk_model();
            if (i == 300) begin
                sample_valid = 1'b1;
                sample_data = 16'h7777;
                #2 n_rst = 1'b0;
                #1 chk_zero("async reset");
                model_reset();
                #1 n_rst = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/peak_tracker.md
# peak_tracker

Streaming running-maximum tracker that feeds the 16-bit magnitude comparator and consumes its verdict. Each accepted sample is registered onto the comparator's `a` input against the stored peak on `b`. The returned gt/lt/eq decides whether the peak is replaced, counted, or declared stable. It sits between the sample source and the status/report logic, and accepts one sample per clock, fully pipelined.

## Interface
- STREAK_LEN, 4: consecutive equal-to-peak compares needed to assert `peak_stable`. Legal range 1–15.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- sample_valid  in  1  `sample_data` is valid this cycle.
- sample_data  in  16  unsigned sample.
- clear  in  1  synchronous restart of tracking.
- cmp_gt, cmp_lt, cmp_eq  in  1 each  comparator verdict for (`cmp_a`, `cmp_b`).
- cmp_a  out  16  registered sample under test; drives comparator `a`.
- cmp_b  out  16  current peak; drives comparator `b`.
- peak  out  16  current maximum; equals `cmp_b`.
- peak_valid  out  1  at least one sample captured since reset/clear.
- new_peak  out  1  one-cycle pulse when the peak is loaded or replaced.
- peak_count  out  8  number of peak loads/replacements, saturating at 255.
- peak_stable  out  1  streak counter ≥ STREAK_LEN.
- cmp_error  out  1  sticky: comparator verdict was not one-hot during a compare.

## Operation
- Stage 1: on each edge with `sample_valid`=1, `s_reg` ← `sample_data` and `s_pend` ← 1. Otherwise `s_pend` ← 0. `cmp_a` = `s_reg`.
- Stage 2: a compare is active when `s_pend`=1. Comparator outputs are combinational, so stage 2 uses them in the same cycle.
- FSM states: EMPTY (`peak_valid`=0), TRACK, STABLE (`peak_stable`=1).
- EMPTY + `s_pend`:
  - `peak` ← `s_reg`, ignoring the comparator.
  - `new_peak` pulses, `peak_count` ← 1, streak ← 0.
  - Go to TRACK.
- TRACK/STABLE + `s_pend`, verdict one-hot:
  - gt: `peak` ← `s_reg`, `new_peak` pulses, `peak_count`+1 (saturating), streak ← 0. Go to TRACK.
  - eq: streak+1, saturating at STREAK_LEN. Go to STABLE when streak reaches STREAK_LEN.
  - lt: no change to peak, count, streak, or state.
- Verdict not one-hot (zero or multiple bits set) while comparing in TRACK/STABLE:
  - `cmp_error` ← 1 (sticky).
  - The sample is discarded and all other state is unchanged.
- `clear`=1 has the highest priority on that edge:
  - Go to EMPTY; `peak`, `peak_count`, streak, `s_pend`, `s_reg` and `new_peak` ← 0.
  - A sample presented in the same cycle is dropped; any pending compare is abandoned.
  - `cmp_error` is cleared only by reset, not by `clear`.
- Streak counter is 4 bits. `peak_stable` is a registered output and is 1 exactly in STABLE.
- Width rules:
  - All compares are unsigned 16-bit.
  - `peak_count` holds at 255; it never wraps.
  - 0xFFFF is a legal sample and a legal peak.

## Timing
- Reset (n_rst=0, asynchronous): state EMPTY. `cmp_a`, `cmp_b`, `peak`, `peak_count` = 0. `peak_valid`, `new_peak`, `peak_stable`, `cmp_error` = 0.
- Sample presented before edge k is captured at edge k. It is compared during cycle k→k+1 and its effects are registered at edge k+1.
- `new_peak` is high for exactly cycle k+1→k+2 for that sample.
- Back-to-back samples: sample j+1 is compared against the peak as already updated by sample j. There are no bubbles, stalls or backpressure.
- `peak_stable` rises in the cycle after the STREAK_LEN-th consecutive-eligible eq compare.
- Reset mid-operation: the pending sample is lost and all outputs take their reset values immediately.

## Test plan
- Reset, then samples 0x0010, 0x0020, 0x0015 on consecutive cycles:
  - `peak` goes 0x0010 → 0x0020 and stays 0x0020.
  - `new_peak` pulses twice; `peak_count`=2.
  - `cmp_a`/`cmp_b` present (0x0020, 0x0010), then (0x0015, 0x0020).
- Samples 0x1234 followed by five more 0x1234 (STREAK_LEN=4):
  - `peak_stable` rises after the 4th equal compare.
  - A following 0x1235 drops `peak_stable` and pulses `new_peak`.
- 300 strictly increasing samples: `peak_count` saturates at 255; `peak` = last sample.
- Boundaries, samples 0xFFFF then 0x0000:
  - `peak` stays 0xFFFF (lt path).
  - Force comparator to gt=1, lt=1 on one compare: `cmp_error`=1, the sample is ignored, and `cmp_error` is still 1 after a `clear`.
- Assert `clear` in the same cycle as `sample_valid` (0x0050), with a compare pending:
  - Next cycle state is EMPTY with all counters 0.
  - The following sample 0x0003 loads `peak`=0x0003 with `new_peak`=1 and `peak_count`=1.
- Assert n_rst=0 asynchronously mid-stream (between edges): all outputs zero before the next clock edge; tracking restarts cleanly after release.
